// File: rtl/toy_fetch_rob_pkg.sv
// Shared types and defaults for the fetch return buffer (package toy_pack).
// Entry lifecycle: FREE -> WAIT -> DONE -> FREE, with KILL holding flushed entries until their return lands.
package toy_pack;

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2,
      ST_KILL = 2'd3
   } entry_state_e;

   localparam int DEFAULT_DEPTH      = 8;
   localparam int DEFAULT_DATA_WIDTH = 128;

endpackage

// File: rtl/toy_fetch_rob_entry.sv
// One return-buffer slot: lifecycle state, invalid bit and payload, plus the
// channel-select mux that picks whichever cache return targets this slot.
module toy_fetch_rob_entry
   import toy_pack::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ACK_PORTS  = 2,
   parameter int ID_W       = 3,
   parameter int ENTRY_ID   = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            alloc_i,
   input  logic                            alloc_inv_i,
   input  logic                            bp2_inv_i,
   input  logic                            retire_i,
   input  logic                            flush_i,
   input  logic [ACK_PORTS-1:0]            ack_vld_i,
   input  logic [ACK_PORTS*ID_W-1:0]       ack_id_i,
   input  logic [ACK_PORTS*DATA_WIDTH-1:0] ack_pld_i,
   output entry_state_e                    state_o,
   output logic                            invalid_o,
   output logic [DATA_WIDTH-1:0]           pld_o,
   output logic                            ack_hit_o,
   output logic [DATA_WIDTH-1:0]           ack_pld_o
);

   localparam logic [ID_W-1:0] MY_ID = ID_W'(ENTRY_ID);

   entry_state_e          state_q, state_d;
   logic                  invalid_q, invalid_d;
   logic [DATA_WIDTH-1:0] pld_q, pld_d;
   logic [ACK_PORTS-1:0]  ackMatch;
   logic [DATA_WIDTH-1:0] ackPldSel;

   always_comb begin
      ackMatch  = '0;
      ackPldSel = '0;
      for (int c = 0; c < ACK_PORTS; c++) begin
         ackMatch[c] = ack_vld_i[c] && (ack_id_i[c*ID_W +: ID_W] == MY_ID);
         if (ackMatch[c]) ackPldSel = ack_pld_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign ack_hit_o = |ackMatch;
   assign ack_pld_o = ackPldSel;

   // A return landing in the flush cycle frees the slot outright instead of parking it in KILL.
   always_comb begin
      state_d   = state_q;
      invalid_d = invalid_q;
      pld_d     = pld_q;
      if (ack_hit_o) pld_d = ackPldSel;
      case (state_q)
         ST_FREE: if (alloc_i) state_d = ST_WAIT;
         ST_WAIT: begin
            if (flush_i)        state_d = ack_hit_o ? ST_FREE : ST_KILL;
            else if (ack_hit_o) state_d = retire_i ? ST_FREE : ST_DONE;
         end
         ST_DONE: if (flush_i || retire_i) state_d = ST_FREE;
         ST_KILL: if (ack_hit_o) state_d = ST_FREE;
         default: state_d = ST_FREE;
      endcase
      if (flush_i)        invalid_d = 1'b0;
      else if (alloc_i)   invalid_d = alloc_inv_i;
      else if (bp2_inv_i) invalid_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FREE;
         invalid_q <= 1'b0;
         pld_q     <= '0;
      end else begin
         state_q   <= state_d;
         invalid_q <= invalid_d;
         pld_q     <= pld_d;
      end
   end

   assign state_o   = state_q;
   assign invalid_o = invalid_q;
   assign pld_o     = pld_q;

   assert property (@(posedge clk) disable iff (!rst_n) $countones(ackMatch) <= 1);
   assert property (@(posedge clk) disable iff (!rst_n)
                    ack_hit_o |-> (state_q == ST_WAIT || state_q == ST_KILL));

endmodule

// File: rtl/toy_fetch_rob.sv
// In-order fetch return buffer: entries preallocated in program order, filled out of order by
// cache returns, drained in order. Define TOY_FETCH_ROB_ACK_BYPASS_EN for same-cycle head bypass.
module toy_fetch_rob
   import toy_pack::*;
#(
   parameter  int DEPTH      = DEFAULT_DEPTH,
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int ACK_PORTS  = 2,
   localparam int ID_W       = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            alloc_req_i,
   output logic                            alloc_rdy_o,
   output logic [ID_W-1:0]                 alloc_id_o,
   input  logic [ACK_PORTS-1:0]            ack_vld_i,
   input  logic [ACK_PORTS*ID_W-1:0]       ack_id_i,
   input  logic [ACK_PORTS*DATA_WIDTH-1:0] ack_pld_i,
   output logic                            out_vld_o,
   input  logic                            out_rdy_i,
   output logic [DATA_WIDTH-1:0]           out_pld_o,
   input  logic                            bp2_vld_i,
   input  logic                            bp2_flush_i,
   input  logic                            flush_i,
   output logic                            flush_done_o,
   output logic [ID_W:0]                   occupancy_o
);

`ifdef TOY_FETCH_ROB_ACK_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic [ID_W:0]         wr_q, wr_d, rd_q, rd_d;
   logic [ID_W-1:0]       wrIdx, rdIdx, bp2Idx;
   entry_state_e          entryState [DEPTH];
   logic [DATA_WIDTH-1:0] entryPld [DEPTH];
   logic [DATA_WIDTH-1:0] entryAckPld [DEPTH];
   logic [DEPTH-1:0]      entryInv, entryHit, entryKill;
   logic                  full, empty, alloc, bp2Inv;
   logic                  headDone, headDrop, headBypass, retire;

   assign wrIdx  = wr_q[ID_W-1:0];
   assign rdIdx  = rd_q[ID_W-1:0];
   assign bp2Idx = wrIdx - ID_W'(1);
   assign full   = (wrIdx == rdIdx) && (wr_q[ID_W] != rd_q[ID_W]);
   assign empty  = (wr_q == rd_q);

   // A slot still in KILL owes us a cache return, so allocation waits for it to drain.
   assign alloc_rdy_o = ~full & ~flush_i & (entryState[wrIdx] != ST_KILL);
   assign alloc       = alloc_req_i & alloc_rdy_o;
   assign alloc_id_o  = wrIdx;
   assign bp2Inv      = bp2_vld_i & bp2_flush_i & ~empty;

   assign headDone   = (entryState[rdIdx] == ST_DONE);
   assign headDrop   = headDone & entryInv[rdIdx];
   assign headBypass = BYPASS_EN & (entryState[rdIdx] == ST_WAIT) & ~entryInv[rdIdx] & entryHit[rdIdx];
   assign out_vld_o  = (headDone & ~entryInv[rdIdx]) | headBypass;
   assign out_pld_o  = headBypass ? entryAckPld[rdIdx] : entryPld[rdIdx];
   assign retire     = ~flush_i & (headDrop | (out_vld_o & out_rdy_i));

   assign wr_d = wr_q + {{ID_W{1'b0}}, alloc};
   assign rd_d = flush_i ? wr_q : rd_q + {{ID_W{1'b0}}, retire};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   assign occupancy_o  = wr_q - rd_q;
   assign flush_done_o = ~|entryKill;

   for (genvar i = 0; i < DEPTH; i++) begin : gEntry
      toy_fetch_rob_entry #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACK_PORTS  (ACK_PORTS),
         .ID_W       (ID_W),
         .ENTRY_ID   (i)
      ) uEntry (
         .clk         (clk),
         .rst_n       (rst_n),
         .alloc_i     (alloc && (wrIdx == ID_W'(i))),
         .alloc_inv_i (bp2Inv),
         .bp2_inv_i   (bp2Inv && (bp2Idx == ID_W'(i))),
         .retire_i    (retire && (rdIdx == ID_W'(i))),
         .flush_i     (flush_i),
         .ack_vld_i   (ack_vld_i),
         .ack_id_i    (ack_id_i),
         .ack_pld_i   (ack_pld_i),
         .state_o     (entryState[i]),
         .invalid_o   (entryInv[i]),
         .pld_o       (entryPld[i]),
         .ack_hit_o   (entryHit[i]),
         .ack_pld_o   (entryAckPld[i])
      );
      assign entryKill[i] = (entryState[i] == ST_KILL);
   end

endmodule
